// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and 50 MHz timing defaults for key_debounce
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int DEBOUNCE_20MS = 1_000_000;
    localparam int REPEAT_500MS  = 25_000_000;
    localparam int REPEAT_200MS  = 10_000_000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for one asynchronous input with a chosen reset level
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button debouncer with clean level and press/release/repeat/step strobes
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int REPEAT_DELAY    = REPEAT_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_200MS,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic step_pulse
);

    localparam logic ACTIVE_LOW = (KEY_ACTIVE_LOW != 0);
    localparam int   DW         = $clog2(DEBOUNCE_CYCLES);
    localparam int   RMAX       = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int   RW         = (RMAX < 2) ? 1 : $clog2(RMAX);
    localparam logic REPEAT_EN  = (REPEAT_DELAY != 0);

    localparam logic [DW-1:0] CNT_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'((REPEAT_DELAY  > 0) ? REPEAT_DELAY  - 1 : 0);
    localparam logic [RW-1:0] PERIOD_LAST = RW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

    logic key_sync;
    logic pressed_s;

    sync_2ff #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_in),
        .q   (key_sync)
    );

    assign pressed_s = key_sync ^ ACTIVE_LOW;

    key_state_t      state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic            rfirst_q, rfirst_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            repeat_q, repeat_d;
    logic            step_q, step_d;
    logic [RW-1:0]   rlimit;

    // The first tick waits the long delay, later ticks use the period.
    assign rlimit = rfirst_q ? DELAY_LAST : PERIOD_LAST;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        rfirst_d  = rfirst_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = DW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = HELD;
                    cnt_d    = '0;
                    level_d  = 1'b1;
                    press_d  = 1'b1;
                    rcnt_d   = '0;
                    rfirst_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            HELD: begin
                if (!pressed_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = DW'(1);
                end else if (REPEAT_EN) begin
                    if (rcnt_q == rlimit) begin
                        repeat_d = 1'b1;
                        rcnt_d   = '0;
                        rfirst_d = 1'b0;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                // Repeat counter is frozen here, so a bounce back to HELD resumes its phase.
                if (pressed_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        step_d = press_d | repeat_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            rfirst_q  <= 1'b1;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            rfirst_q  <= rfirst_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            step_q    <= step_d;
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign step_pulse    = step_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - randomized and directed bench for key_debounce against a behavioural model
module tb_key_debounce;

    localparam int DB  = 8;
    localparam int PER = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key [3];
    logic lvl_o [3];
    logic prs_o [3];
    logic rel_o [3];
    logic rep_o [3];
    logic stp_o [3];
    logic [4:0] dut_vec [3];

    int rdel [3] = '{20, 0, 20};
    bit alow [3] = '{1'b1, 1'b1, 1'b0};

    bit m_s1 [3];
    bit m_s2 [3];
    bit m_lvl [3];
    int m_run [3];
    int m_ticks [3];
    logic [4:0] exp_vec [3] = '{5'b0, 5'b0, 5'b0};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    key_debounce #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(20), .REPEAT_PERIOD(PER), .KEY_ACTIVE_LOW(1)) u_dut0 (
        .clk(clk), .rst(rst), .key_in(key[0]), .key_level(lvl_o[0]), .press_pulse(prs_o[0]),
        .release_pulse(rel_o[0]), .repeat_pulse(rep_o[0]), .step_pulse(stp_o[0]));

    key_debounce #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(PER), .KEY_ACTIVE_LOW(1)) u_dut1 (
        .clk(clk), .rst(rst), .key_in(key[1]), .key_level(lvl_o[1]), .press_pulse(prs_o[1]),
        .release_pulse(rel_o[1]), .repeat_pulse(rep_o[1]), .step_pulse(stp_o[1]));

    key_debounce #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(20), .REPEAT_PERIOD(PER), .KEY_ACTIVE_LOW(0)) u_dut2 (
        .clk(clk), .rst(rst), .key_in(key[2]), .key_level(lvl_o[2]), .press_pulse(prs_o[2]),
        .release_pulse(rel_o[2]), .repeat_pulse(rep_o[2]), .step_pulse(stp_o[2]));

    for (genvar g = 0; g < 3; g++) begin : g_vec
        assign dut_vec[g] = {lvl_o[g], prs_o[g], rel_o[g], rep_o[g], stp_o[g]};
    end

    // Reference: level flips after DB consecutive opposite samples; held samples advance a
    // hold clock that ticks at DELAY, DELAY+PER, DELAY+2*PER, ...
    function automatic void model_step(int i, bit r, bit kp);
        bit p, pr, rl, rp;
        if (r) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_lvl[i] = 1'b0;
            m_run[i] = 0; m_ticks[i] = 0; exp_vec[i] = 5'b0;
            return;
        end
        p = m_s2[i]; m_s2[i] = m_s1[i]; m_s1[i] = kp;
        pr = 1'b0; rl = 1'b0; rp = 1'b0;
        if (p != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
                m_lvl[i] = p;
                m_run[i] = 0;
                if (p) begin pr = 1'b1; m_ticks[i] = 0; end
                else rl = 1'b1;
            end
        end else begin
            if (m_lvl[i] && m_run[i] == 0 && rdel[i] != 0) begin
                m_ticks[i]++;
                if (m_ticks[i] >= rdel[i] && (m_ticks[i] - rdel[i]) % PER == 0) rp = 1'b1;
            end
            m_run[i] = 0;
        end
        exp_vec[i] = {m_lvl[i], pr, rl, rp, pr | rp};
    endfunction

    task automatic tick();
        bit r;
        bit kp [3];
        r = rst;
        for (int i = 0; i < 3; i++) kp[i] = alow[i] ? !key[i] : key[i];
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, r, kp[i]);
        #1;
        cyc++;
    endtask

    task automatic idle_keys();
        key[0] = 1'b1; key[1] = 1'b1; key[2] = 1'b0;
    endtask

    task automatic test_reset();
        idle_keys();
        rst = 1'b1;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_vec[i] !== 5'b0) begin
                errors++;
                $display("FAIL reset_state inst%0d got=%b exp=00000", i, dut_vec[i]);
            end
        end
        rst = 1'b0;
        repeat (6) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec[i] !== exp_vec[i]) begin
                    errors++;
                    $display("FAIL reset_idle inst%0d cyc%0d got=%b exp=%b", i, cyc, dut_vec[i], exp_vec[i]);
                end
            end
        end
    endtask

    task automatic test_clean_press();
        int t0, press_at, rel_at, nrep, nstep, first_rep, last_rep;
        press_at = -1; rel_at = -1; nrep = 0; nstep = 0; first_rep = -1; last_rep = -1;
        key[0] = 1'b0; t0 = cyc;
        for (int n = 0; n < 60; n++) begin
            if (n == 40) key[0] = 1'b1;
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec[i] !== exp_vec[i]) begin
                    errors++;
                    $display("FAIL clean_press inst%0d cyc%0d got=%b exp=%b", i, cyc, dut_vec[i], exp_vec[i]);
                end
            end
            if (prs_o[0]) press_at = cyc - t0;
            if (rel_o[0]) rel_at = cyc - t0 - 40;
            if (stp_o[0]) nstep++;
            if (rep_o[0]) begin
                nrep++;
                if (first_rep < 0) first_rep = cyc - t0;
                last_rep = cyc - t0;
            end
        end
        checks++; if (press_at !== 10) begin errors++; $display("FAIL press_latency got=%0d exp=10", press_at); end
        checks++; if (nrep !== 3) begin errors++; $display("FAIL repeat_count got=%0d exp=3", nrep); end
        checks++; if (first_rep !== 30 || last_rep !== 40) begin
            errors++; $display("FAIL repeat_timing got=%0d..%0d exp=30..40", first_rep, last_rep); end
        checks++; if (nstep !== 4) begin errors++; $display("FAIL step_count got=%0d exp=4", nstep); end
        checks++; if (rel_at !== 10) begin errors++; $display("FAIL release_latency got=%0d exp=10", rel_at); end
    endtask

    task automatic test_bounce();
        int seq [5] = '{5, 2, 5, 20, 0};
        int act;
        act = 0;
        for (int s = 0; s < 4; s++) begin
            key[0] = (s % 2 == 1) || (s == 3);
            for (int n = 0; n < seq[s]; n++) begin
                tick();
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (dut_vec[i] !== exp_vec[i]) begin
                        errors++;
                        $display("FAIL bounce inst%0d cyc%0d got=%b exp=%b", i, cyc, dut_vec[i], exp_vec[i]);
                    end
                end
                if (dut_vec[0] !== 5'b0) act++;
            end
        end
        checks++; if (act !== 0) begin errors++; $display("FAIL bounce_activity got=%0d exp=0", act); end
    endtask

    task automatic test_release_bounce();
        int npress, nrel, lvl_drop;
        npress = 0; nrel = 0; lvl_drop = 0;
        key[0] = 1'b0;
        repeat (12) tick();
        for (int n = 0; n < 20; n++) begin
            key[0] = (n < 3);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec[i] !== exp_vec[i]) begin
                    errors++;
                    $display("FAIL release_bounce inst%0d cyc%0d got=%b exp=%b", i, cyc, dut_vec[i], exp_vec[i]);
                end
            end
            if (prs_o[0]) npress++;
            if (rel_o[0]) nrel++;
            if (!lvl_o[0]) lvl_drop++;
        end
        checks++;
        if (npress !== 0 || nrel !== 0 || lvl_drop !== 0) begin
            errors++;
            $display("FAIL release_bounce_quiet got=p%0d r%0d d%0d exp=p0 r0 d0", npress, nrel, lvl_drop);
        end
        key[0] = 1'b1;
        repeat (14) tick();
    endtask

    task automatic test_reset_mid_hold();
        int p_at, t_rst, new_press, nrel;
        p_at = -1; new_press = -1; nrel = 0; t_rst = 0;
        key[0] = 1'b0;
        for (int n = 0; n < 60; n++) begin
            rst = (p_at >= 0 && cyc == p_at + 12);
            if (rst) t_rst = cyc + 1;
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec[i] !== exp_vec[i]) begin
                    errors++;
                    $display("FAIL reset_mid_hold inst%0d cyc%0d got=%b exp=%b", i, cyc, dut_vec[i], exp_vec[i]);
                end
            end
            if (t_rst != 0 && cyc == t_rst) begin
                checks++;
                if (dut_vec[0] !== 5'b0) begin
                    errors++; $display("FAIL reset_clears got=%b exp=00000", dut_vec[0]);
                end
            end
            if (prs_o[0] && p_at < 0) p_at = cyc;
            else if (prs_o[0]) new_press = cyc - t_rst;
            if (rel_o[0]) nrel++;
        end
        rst = 1'b0;
        checks++; if (new_press !== 10) begin errors++; $display("FAIL repress_latency got=%0d exp=10", new_press); end
        checks++; if (nrel !== 0) begin errors++; $display("FAIL reset_no_release got=%0d exp=0", nrel); end
        key[0] = 1'b1;
        repeat (14) tick();
    endtask

    task automatic test_no_repeat();
        int np, nr, nl;
        np = 0; nr = 0; nl = 0;
        key[1] = 1'b0;
        for (int n = 0; n < 215; n++) begin
            if (n == 200) key[1] = 1'b1;
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec[i] !== exp_vec[i]) begin
                    errors++;
                    $display("FAIL no_repeat inst%0d cyc%0d got=%b exp=%b", i, cyc, dut_vec[i], exp_vec[i]);
                end
            end
            np += prs_o[1]; nr += rep_o[1]; nl += rel_o[1];
        end
        checks++;
        if (np !== 1 || nr !== 0 || nl !== 1) begin
            errors++; $display("FAIL no_repeat_counts got=p%0d r%0d l%0d exp=p1 r0 l1", np, nr, nl);
        end
    endtask

    task automatic test_active_high();
        int t0, p_at, r_at, nrep;
        p_at = -1; r_at = -1; nrep = 0;
        key[2] = 1'b1; t0 = cyc;
        for (int n = 0; n < 50; n++) begin
            if (n == 30) key[2] = 1'b0;
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec[i] !== exp_vec[i]) begin
                    errors++;
                    $display("FAIL active_high inst%0d cyc%0d got=%b exp=%b", i, cyc, dut_vec[i], exp_vec[i]);
                end
            end
            if (prs_o[2]) p_at = cyc - t0;
            if (rel_o[2]) r_at = cyc - t0 - 30;
            nrep += rep_o[2];
        end
        checks++;
        if (p_at !== 10 || r_at !== 10 || nrep !== 1) begin
            errors++; $display("FAIL active_high_timing got=p%0d r%0d n%0d exp=p10 r10 n1", p_at, r_at, nrep);
        end
    endtask

    task automatic test_random();
        int left [3] = '{0, 0, 0};
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (left[i] == 0) begin
                    key[i] = ~key[i];
                    left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 12);
                end
                left[i]--;
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec[i] !== exp_vec[i]) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d got=%b exp=%b", i, cyc, dut_vec[i], exp_vec[i]);
                end
            end
        end
        idle_keys();
        repeat (14) tick();
    endtask

    initial begin
        idle_keys();
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_reset_mid_hold();
        test_no_repeat();
        test_active_high();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions one raw mechanical push-button input for the PWM duty-step logic directly downstream.
- Synchronises the input and debounces press and release with a stability counter.
- Emits a clean level plus single-cycle press, release and auto-repeat strobes.
- Downstream consumes press_pulse/step_pulse in place of a raw key level, so one physical press moves duty exactly one step.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a press or a release (20 ms at 50 MHz); must be >= 2.
- REPEAT_DELAY, 25000000, cycles after press_pulse before the first repeat_pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 10000000, cycles between successive repeat_pulse while held; must be >= 1.
- KEY_ACTIVE_LOW, 1, 1 = key_in low means pressed; 0 = high means pressed.

Ports:
- clk  input  1  system clock, all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- key_in  input  1  raw asynchronous button input
- key_level  output  1  debounced pressed state, 1 = pressed
- press_pulse  output  1  one-cycle strobe on accepted press
- release_pulse  output  1  one-cycle strobe on accepted release
- repeat_pulse  output  1  one-cycle strobe per auto-repeat tick while held
- step_pulse  output  1  press_pulse OR repeat_pulse, registered

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst).
  - Outputs: key_level=0, all pulses 0.
  - State: FSM=IDLE, counters=0, synchroniser flops loaded with the not-pressed level.
- Input path: two-flop synchroniser on key_in, then polarity normalisation to pressed_s (1 = pressed). Adds 2 cycles of latency.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. One debounce counter; one repeat counter. Each is $clog2 of its largest parameter wide and saturates safely.
- IDLE: pressed_s=1 -> PRESS_WAIT with cnt=1.
- PRESS_WAIT:
  - pressed_s=0 -> IDLE (bounce rejected, no pulse).
  - Otherwise cnt++.
  - When cnt reaches DEBOUNCE_CYCLES -> HELD, key_level<=1, press_pulse=1 for exactly one cycle, repeat counter cleared.
- HELD:
  - pressed_s=0 -> RELEASE_WAIT with cnt=1.
  - Else, if REPEAT_DELAY!=0: repeat counter counts. The first repeat_pulse comes REPEAT_DELAY cycles after press_pulse, then one every REPEAT_PERIOD cycles, indefinitely.
- RELEASE_WAIT:
  - pressed_s=1 -> HELD. No new press_pulse; key_level stays 1; repeat counter is not reset, so repeat timing continues.
  - Otherwise cnt++.
  - At DEBOUNCE_CYCLES -> IDLE, key_level<=0, release_pulse=1 for one cycle.
  - Suppress any repeat_pulse while in RELEASE_WAIT.
- Output timing: all pulses are registered, aligned with the key_level transition cycle. press_pulse and release_pulse are never high in the same cycle.
- Latency: for a clean press stable from cycle 0, press_pulse is high in cycle DEBOUNCE_CYCLES+2 (±1 for sampling phase; the bench checks the exact value with its fixed stimulus alignment).
- Glitch shorter than DEBOUNCE_CYCLES: no output activity in either direction.
- Reset asserted mid-press or mid-hold: return to IDLE next edge, key_level=0, no release_pulse. A still-held key after reset must be re-debounced and yields a fresh press_pulse.
- Held forever: repeat counter wraps per period, with no overflow or missed ticks.

Decomposition:
- Package key_pkg holds:
  - the FSM state enum key_state_t (2-bit encoding);
  - the default timing constants for a 50 MHz clock: DEBOUNCE_20MS, REPEAT_500MS, REPEAT_200MS.
- One natural sub-module: sync_2ff (parameterised reset value). It is reusable for the other async inputs in the design.
- The FSM and counters stay in key_debounce.

Test Plan:
- Bench parameters used throughout: DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, KEY_ACTIVE_LOW=1.
- Clean press: key_in 1->0 held 40 cycles, then released.
  - press_pulse exactly once, 10 cycles after the edge; key_level=1 from that cycle.
  - repeat_pulse at +20, +25, +30 after press_pulse.
  - step_pulse = press + repeats (4 total).
  - release_pulse once, 10 cycles after the release edge.
- Bounce: pulse key_in low for 5 cycles, high 2, low 5, high -> zero pulses, key_level stays 0.
- Release bounce: while HELD, key_in high for 3 cycles then low again -> no release_pulse, no second press_pulse, key_level stays 1.
- Reset mid-hold: assert rst for 1 cycle at press_pulse+12 while key still low.
  - Outputs 0 the next cycle.
  - New press_pulse 10 cycles after rst drops.
  - No release_pulse.
- REPEAT_DELAY=0, hold 200 cycles -> exactly one press_pulse, zero repeat_pulse, one release_pulse after release.
- KEY_ACTIVE_LOW=0, key_in 0->1 for 30 cycles -> same timing as the clean-press scenario with polarity inverted.
